// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium byte cipher wrapper.
package trivium_pkg;

  localparam int unsigned KS_BYTE_BITS = 8;
  localparam int unsigned BIT_CNT_W    = $clog2(KS_BYTE_BITS);

  typedef enum logic [1:0] {
    WAIT_WARM,
    FILL,
    FULL
  } state_e;

endpackage : trivium_pkg

// File: rtl/trivium_byte_cipher.sv
// Packs serial Trivium keystream bits into bytes and XORs them with a byte stream
// under valid/ready handshaking; each keystream byte is consumed exactly once.
module trivium_byte_cipher
  import trivium_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    warm_up_complete,
  input  logic                    key_stream,
  output logic                    ks_en,
  input  logic                    sync_clear,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  input  logic                    out_ready,
  output logic [CNT_WIDTH-1:0]    byte_count
);

  state_e                  state_q, state_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [KS_BYTE_BITS-1:0] ks_byte_q, ks_byte_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]    byte_count_q, byte_count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_WARM;
      bit_cnt_q    <= '0;
      ks_byte_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ks_byte_q    <= ks_byte_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ks_byte_d    = ks_byte_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    byte_count_d = byte_count_q;
    ks_en        = 1'b0;
    in_ready     = 1'b0;

    if (sync_clear) begin
      state_d      = WAIT_WARM;
      bit_cnt_d    = '0;
      ks_byte_d    = '0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      byte_count_d = '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        WAIT_WARM: begin
          if (warm_up_complete) begin
            state_d = FILL;
          end
        end
        FILL: begin
          if (!warm_up_complete) begin
            state_d   = WAIT_WARM;
            bit_cnt_d = '0;
            ks_byte_d = '0;
          end else begin
            ks_en                = 1'b1;
            ks_byte_d[bit_cnt_q] = key_stream;
            if (bit_cnt_q == BIT_CNT_W'(KS_BYTE_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = FULL;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (!warm_up_complete) begin
            state_d   = WAIT_WARM;
            bit_cnt_d = '0;
            ks_byte_d = '0;
          end else begin
            // A pending result blocks intake unless it drains this same cycle.
            in_ready = !out_valid_q || out_ready;
            if (in_valid && in_ready) begin
              out_data_d   = in_data ^ ks_byte_q;
              out_valid_d  = 1'b1;
              byte_count_d = byte_count_q + CNT_WIDTH'(1);
              state_d      = FILL;
            end
          end
        end
        default: begin
          state_d = WAIT_WARM;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign byte_count = byte_count_q;

endmodule : trivium_byte_cipher

// File: tb/tb_trivium_byte_cipher.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// keystream-bit queue / expected-output queue reference model.
module tb_trivium_byte_cipher;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          warm_up_complete;
  logic          key_stream;
  logic          ks_en;
  logic          sync_clear;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic [CW-1:0] byte_count;

  always #5 clk = ~clk;

  trivium_byte_cipher #(.CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .warm_up_complete (warm_up_complete),
    .key_stream       (key_stream),
    .ks_en            (ks_en),
    .sync_clear       (sync_clear),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .byte_count       (byte_count)
  );

  int         n_chk;
  int         n_fail;
  bit         ks_q[$];
  logic [7:0] exp_q[$];
  int         cnt;
  bit         use_pat;
  logic [7:0] pat;
  int         pat_idx;
  logic       obs_ks_en;
  logic       obs_acc;
  logic       obs_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs and advance the model, then wait posedge.
  task automatic cycle(input logic w, input logic sc, input logic iv,
                       input logic [7:0] id, input logic ordy);
    logic [7:0] kb;
    @(negedge clk);
    warm_up_complete = w;
    sync_clear       = sc;
    in_valid         = iv;
    in_data          = id;
    out_ready        = ordy;
    key_stream       = use_pat ? pat[3'(pat_idx)] : 1'($urandom);
    #1;
    obs_ks_en = ks_en;
    obs_rdy   = in_ready;
    obs_acc   = iv & in_ready;
    check("byte_count", 32'(byte_count), 32'(cnt));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
    if (sc || !w) begin
      check("ks_en_gated", 32'(ks_en), 32'(0));
      check("in_ready_gated", 32'(in_ready), 32'(0));
    end
    if (in_ready) check("ready_needs_full_byte", 32'(ks_q.size()), 32'(8));
    if (sc) begin
      ks_q.delete();
      exp_q.delete();
      cnt = 0;
    end else begin
      if (out_valid && ordy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (ks_en) begin
        ks_q.push_back(key_stream);
        check("fill_len", 32'(ks_q.size() <= 8), 32'(1));
        pat_idx++;
      end
      if (obs_acc) begin
        kb = '0;
        for (int i = 0; i < 8 && i < ks_q.size(); i++) kb[i] = ks_q[i];
        exp_q.push_back(id ^ kb);
        cnt = (cnt + 1) % (1 << CW);
        ks_q.delete();
      end
      if (!w) ks_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic fill_until_ready(input string tag);
    int nks;
    nks = 0;
    obs_rdy = 1'b0;
    for (int i = 0; i < 20 && !obs_rdy; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      if (obs_ks_en) nks++;
    end
    check(tag, 32'(nks), 32'(8));
  endtask

  initial begin
    int n_acc;
    int gap;
    n_chk = 0; n_fail = 0; cnt = 0;
    use_pat = 1'b1; pat = 8'h8D; pat_idx = 0;
    rst = 1'b1;
    warm_up_complete = 1'b0; key_stream = 1'b0; sync_clear = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2 rst = 1'b0;
    warm_up_complete = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ks_en", 32'(ks_en), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_byte_count", 32'(byte_count), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Pattern 1,0,1,1,0,0,0,1 forms 0x8D; 0xFF ^ 0x8D = 0x72.
    fill_until_ready("first_fill_ks_cycles");
    cycle(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    check("first_accept", 32'(obs_acc), 32'(1));
    #1;
    check("first_out_data", 32'(out_data), 32'h72);
    check("first_out_valid", 32'(out_valid), 32'(1));
    check("first_byte_count", 32'(byte_count), 32'(1));

    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      if (obs_acc) n_acc++;
    end
    check("stall_no_accept", 32'(n_acc), 32'(0));
    check("stall_in_ready", 32'(in_ready), 32'(0));
    check("stall_out_data", 32'(out_data), 32'h72);
    cycle(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    check("release_accept", 32'(obs_acc), 32'(1));

    gap = 0;
    for (int i = 1; i <= 20 && gap == 0; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'h3C, 1'b1);
      if (obs_acc) gap = i;
    end
    check("throughput_gap", 32'(gap), 32'(9));

    // Drop warm-up after four fill bits, then refill from scratch.
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("warm_drop_ks_en", 32'(obs_ks_en), 32'(0));
    fill_until_ready("refill_ks_cycles");

    cycle(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1);
    check("clr_no_accept", 32'(obs_acc), 32'(0));
    #1;
    check("clr_out_valid", 32'(out_valid), 32'(0));
    check("clr_byte_count", 32'(byte_count), 32'(0));
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_wait_warm", 32'(obs_ks_en), 32'(0));

    use_pat = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 250 && n_acc < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1);
      if (obs_acc) n_acc++;
    end
    check("wrap_accepts", 32'(n_acc), 32'(16));
    #1;
    check("wrap_byte_count", 32'(byte_count), 32'(0));

    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 127) == 0),
            1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_trivium_byte_cipher
